// File: rtl/input_port_fifo_pkg.sv
// Shared architecture constants for the input port: data width, FIFO depth,
// status byte bit positions and the handshake FSM state type.
package input_port_fifo_pkg;

  localparam int unsigned ARCH_DATA_WIDTH  = 8;
  localparam int unsigned INPUT_FIFO_DEPTH = 4;

  // Status byte bit positions
  localparam int unsigned STAT_AVAIL   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_UFLOW   = 2;
  localparam int unsigned STAT_CNT_LSB = 4;

  typedef enum logic {IN_IDLE, IN_ACK} in_port_state_t;

endpackage

// File: rtl/input_port_fifo_core.sv
// FIFO core for the input port: flop storage, wrapping read/write pointers
// (one extra MSB to tell full from empty), occupancy count and head byte.
module input_port_fifo_core #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned PW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full,
  output logic                  full_next,
  output logic [PW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         wr_nxt, rd_nxt;

  assign wr_nxt = wr_ptr + PW'(push);
  assign rd_nxt = rd_ptr + PW'(pop);

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign full_next = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer registers; callers guarantee no push when full, no pop when empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/input_port_fifo.sv
// CPU-side input port: external source pushes bytes into a small FIFO, the CPU
// pops them and reads a status byte. Default build uses a registered
// valid/ready handshake; defining INPUT_PORT_SYNC_EN switches to a
// synchronised 4-phase handshake driven by an IDLE/ACK FSM.
module input_port_fifo
  import input_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARCH_DATA_WIDTH,
  parameter int unsigned DEPTH      = INPUT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ext_data_in,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  cpu_rd_en,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic [DATA_WIDTH-1:0] cpu_status_out,
  input  logic                  cpu_status_clr,
  output logic                  data_available
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic          push, pop;
  logic          empty, full, full_next;
  logic [PW-1:0] count;
  logic          underflow;

  // A pop on an empty FIFO is dropped (and flagged), even alongside a push
  assign pop = cpu_rd_en && !empty;

  input_port_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .wr_data   (ext_data_in),
    .head      (cpu_data_out),
    .empty     (empty),
    .full      (full),
    .full_next (full_next),
    .count     (count)
  );

`ifdef INPUT_PORT_SYNC_EN
  logic [1:0]     sync;
  logic           sync_valid;
  in_port_state_t state, state_nxt;

  assign sync_valid = sync[1];
  assign ext_ready  = (state == IN_ACK);

  // Two-flop synchroniser for the asynchronous source valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], ext_valid};
  end

  // Handshake state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IN_IDLE;
    else        state <= state_nxt;
  end

  // Capture once per valid pulse in IDLE, then hold ACK until valid drops
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IN_IDLE: if (sync_valid && !full) begin
        push      = 1'b1;
        state_nxt = IN_ACK;
      end
      IN_ACK:  if (!sync_valid) state_nxt = IN_IDLE;
      default: state_nxt = IN_IDLE;
    endcase
  end

  logic unused_full_next;
  assign unused_full_next = full_next;
`else
  logic ready_q;

  assign ext_ready = ready_q;
  assign push      = ext_valid && ready_q;

  // Ready registered from next-cycle fullness so a push never lands on a full FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_q <= 1'b0;
    else        ready_q <= !full_next;
  end
`endif

  // Sticky underflow; a same-cycle underflowing pop beats the clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     underflow <= 1'b0;
    else if (cpu_rd_en && empty)    underflow <= 1'b1;
    else if (cpu_status_clr)        underflow <= 1'b0;
  end

  // Status byte assembly
  always_comb begin
    cpu_status_out                      = '0;
    cpu_status_out[STAT_AVAIL]          = !empty;
    cpu_status_out[STAT_FULL]           = full;
    cpu_status_out[STAT_UFLOW]          = underflow;
    cpu_status_out[STAT_CNT_LSB +: 3]   = 3'(count);
  end

  assign data_available = !empty;

endmodule

// File: tb/tb_input_port_fifo.sv
module tb_input_port_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ext_data_in;
  logic       ext_valid;
  logic       ext_ready;
  logic       cpu_rd_en;
  logic [7:0] cpu_data_out;
  logic [7:0] cpu_status_out;
  logic       cpu_status_clr;
  logic       data_available;

  int vectors = 0;
  int errors  = 0;

  input_port_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ext_data_in    (ext_data_in),
    .ext_valid      (ext_valid),
    .ext_ready      (ext_ready),
    .cpu_rd_en      (cpu_rd_en),
    .cpu_data_out   (cpu_data_out),
    .cpu_status_out (cpu_status_out),
    .cpu_status_clr (cpu_status_clr),
    .data_available (data_available)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ext_valid = 1'b0; ext_data_in = '0; cpu_rd_en = 1'b0; cpu_status_clr = 1'b0;
    tick(); tick();
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", cpu_data_out); end
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ext_ready); end
    vectors++; if (data_available !== 1'b0) begin errors++; $display("FAIL rst_avail got %b exp 0", data_available); end
    reset = 1'b1;
    #1;
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_pre got %b exp 0", ext_ready); end
    tick();
    vectors++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_post got %b exp 1", ext_ready); end
    // queue two bytes then reset mid-run
    ext_valid = 1'b1; ext_data_in = 8'h77; tick();
    ext_data_in = 8'h88; tick();
    ext_valid = 1'b0;
    vectors++; if (cpu_status_out !== 8'h21) begin errors++; $display("FAIL two_queued got %h exp 21", cpu_status_out); end
    reset = 1'b0;
    #1;
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL midrst_status got %h exp 00", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", cpu_data_out); end
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", ext_ready); end
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL midrel_ready_pre got %b exp 0", ext_ready); end
    tick();
    vectors++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL midrel_ready_post got %b exp 1", ext_ready); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    ext_valid = 1'b1; ext_data_in = bytes[0]; tick();
    vectors++; if (cpu_status_out !== 8'h11) begin errors++; $display("FAIL first_push_status got %h exp 11", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'h11) begin errors++; $display("FAIL first_push_head got %h exp 11", cpu_data_out); end
    for (int i = 1; i < 4; i++) begin
      ext_data_in = bytes[i]; tick();
    end
    ext_valid = 1'b0;
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", ext_ready); end
    vectors++; if (cpu_status_out !== 8'h43) begin errors++; $display("FAIL full_status got %h exp 43", cpu_status_out); end
    cpu_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (cpu_data_out !== bytes[i]) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, cpu_data_out, bytes[i]); end
      tick();
      if (i == 0) begin
        vectors++; if (cpu_status_out !== 8'h31) begin errors++; $display("FAIL after_pop1_status got %h exp 31", cpu_status_out); end
        vectors++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL after_pop1_ready got %b exp 1", ext_ready); end
      end
    end
    cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL drained_status got %h exp 00", cpu_status_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_head [5] = '{8'hA2, 8'hA3, 8'hB0, 8'hC0, 8'hC1};
    logic [7:0] tail [3]     = '{8'hC2, 8'hC3, 8'hC4};
    ext_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_data_in = 8'hA0 + 8'(i); tick();
    end
    // full: offer B0 while popping A0; ready is low so only the pop happens
    ext_data_in = 8'hB0; cpu_rd_en = 1'b1; tick();
    cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h31) begin errors++; $display("FAIL full_pop_status got %h exp 31", cpu_status_out); end
    tick();
    vectors++; if (cpu_status_out !== 8'h43) begin errors++; $display("FAIL refill_status got %h exp 43", cpu_status_out); end
    vectors++; if (ext_ready !== 1'b0) begin errors++; $display("FAIL refill_ready got %b exp 0", ext_ready); end
    tick();
    vectors++; if (cpu_status_out !== 8'h43) begin errors++; $display("FAIL no_extra_push got %h exp 43", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'hA1) begin errors++; $display("FAIL refill_head got %h exp A1", cpu_data_out); end
    ext_valid = 1'b0; cpu_rd_en = 1'b1; tick();
    // three queued (A2 A3 B0): now push and pop together for five cycles
    ext_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ext_data_in = 8'hC0 + 8'(i);
      #1;
      vectors++; if (cpu_data_out !== exp_head[i]) begin errors++; $display("FAIL wrap_head_%0d got %h exp %h", i, cpu_data_out, exp_head[i]); end
      tick();
      vectors++; if (cpu_status_out !== 8'h31) begin errors++; $display("FAIL wrap_status_%0d got %h exp 31", i, cpu_status_out); end
    end
    ext_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (cpu_data_out !== tail[i]) begin errors++; $display("FAIL tail_%0d got %h exp %h", i, cpu_data_out, tail[i]); end
      tick();
    end
    cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL wrap_drained got %h exp 00", cpu_status_out); end
  endtask

  task automatic test_underflow();
    cpu_rd_en = 1'b1; tick();
    cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h04) begin errors++; $display("FAIL uflow_set got %h exp 04", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'h00) begin errors++; $display("FAIL uflow_data got %h exp 00", cpu_data_out); end
    cpu_status_clr = 1'b1; tick();
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL uflow_clr got %h exp 00", cpu_status_out); end
    cpu_rd_en = 1'b1; tick();
    cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h04) begin errors++; $display("FAIL clr_vs_set got %h exp 04", cpu_status_out); end
    tick();
    cpu_status_clr = 1'b0;
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL uflow_clr2 got %h exp 00", cpu_status_out); end
    // push and pop on empty: push lands, pop ignored, underflow flagged
    ext_valid = 1'b1; ext_data_in = 8'h5A; cpu_rd_en = 1'b1; tick();
    ext_valid = 1'b0; cpu_rd_en = 1'b0;
    vectors++; if (cpu_status_out !== 8'h15) begin errors++; $display("FAIL push_pop_empty got %h exp 15", cpu_status_out); end
    vectors++; if (cpu_data_out !== 8'h5A) begin errors++; $display("FAIL push_pop_head got %h exp 5A", cpu_data_out); end
    vectors++; if (data_available !== 1'b1) begin errors++; $display("FAIL push_pop_avail got %b exp 1", data_available); end
    cpu_rd_en = 1'b1; cpu_status_clr = 1'b1; tick();
    cpu_rd_en = 1'b0; cpu_status_clr = 1'b0;
    vectors++; if (cpu_status_out !== 8'h00) begin errors++; $display("FAIL final_status got %h exp 00", cpu_status_out); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/input_port_fifo.md
Name: input_port_fifo

Overview:
- CPU-side input port: the receiving counterpart of `output_port_1`; carries bytes from an external source into the CPU.
- External source pushes bytes over a valid/ready handshake into a small FIFO.
- CPU pops bytes and reads a status byte through memory-mapped read strobes decoded in `computer`.
- Sits beside the output port on the peripheral bus.

Parameters:
- DATA_WIDTH, 8 (from arch_defs_pkg): data byte width.
- DEPTH, 4: FIFO entries; allowed values 2 or 4 only, so the count fits status[6:4].

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ext_data_in  input  DATA_WIDTH  byte from external source.
- ext_valid  input  1  source has a byte.
- ext_ready  output  1  port accepts a byte.
- cpu_rd_en  input  1  one-cycle pop strobe from CPU load.
- cpu_data_out  output  DATA_WIDTH  FIFO head; 0x00 when empty.
- cpu_status_out  output  DATA_WIDTH  status byte.
- cpu_status_clr  input  1  clears sticky underflow.
- data_available  output  1  FIFO non-empty, for CPU polling/branch.

Behaviour:
- Reset (reset==0, async):
  - rd/wr pointers = 0; underflow = 0; ext_ready = 0.
  - cpu_data_out = 0x00; cpu_status_out = 0x00; data_available = 0.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and LSBs are equal.
  - empty = pointers equal.
  - count = wr_ptr - rd_ptr, modulo width.
- Storage is a flop array, no reset needed.
- cpu_data_out = mem[rd_ptr] when !empty, else 0x00 (combinational from registers).
- Pop: on clk edge when cpu_rd_en && !empty, rd_ptr+1. cpu_data_out shows the popped byte during the strobe cycle.
- Pop when empty: pointers unchanged; underflow set to 1 (sticky).
- cpu_status_clr clears underflow. If clr and an underflowing pop occur in the same cycle, set wins.
- Status byte:
  - bit0 = !empty
  - bit1 = full
  - bit2 = underflow
  - bits6:4 = count
  - bits 3 and 7 = 0
- Synchronous handshake (default):
  - ext_ready is registered; ext_ready = !full_next. It goes to 1 on the first clk edge after reset release.
  - Transfer occurs on an edge where ext_valid && ext_ready.
  - Push when full never happens, because ready is low.
  - Simultaneous push and pop both take effect; count is unchanged.
  - Push and pop on an empty FIFO in the same cycle: push takes effect, pop is ignored, underflow is set.
- Latency: a byte accepted at edge N is visible on cpu_data_out / data_available after edge N.

Optional Feature:
- Macro: INPUT_PORT_SYNC_EN.
- When defined:
  - ext_valid passes through a 2-flop synchronizer (reset to 0).
  - Handshake becomes 4-phase, driven by an FSM with states IDLE and ACK.
  - IDLE (ext_ready=0): if sync_valid==1 and !full, capture ext_data_in, push, go to ACK.
  - ACK (ext_ready=1): hold until sync_valid==0, then go to IDLE.
  - Valid-to-ready latency is 3 cycles.
  - Full while in IDLE: wait, no capture.
  - Reset mid-handshake: return to IDLE with ext_ready=0; the byte is lost if not yet pushed.
  - Source must hold ext_data_in stable while ext_valid is high.
- When not defined: synchronous valid/ready handshake as described in Behaviour; no synchronizer, no FSM.

Decomposition:
- arch_defs_pkg additions:
  - Status bit index constants: STAT_AVAIL=0, STAT_FULL=1, STAT_UFLOW=2, STAT_CNT_LSB=4.
  - typedef enum logic {IN_IDLE, IN_ACK} in_port_state_t.
  - INPUT_FIFO_DEPTH constant.
- One sub-module: fifo_core (storage, pointers, full/empty/count). The top level holds the handshake, status logic and the optional FSM.

Test Plan:
- Reset mid-run with 2 bytes queued, then release → status=0x00, ext_ready rises 1 cycle after release, cpu_data_out=0x00.
- Push 0x11, 0x22, 0x33, 0x44 back-to-back → ext_ready=0 after 4th push, status=0x43; pop four times → reads 11, 22, 33, 44 in order, then status=0x00.
- Full FIFO, ext_valid=1 plus one pop → exactly one new byte accepted, count returns to 4; then 5 push/pop cycles verify pointer wrap and ordering.
- Pop on empty → status=0x04; cpu_status_clr → 0x00; clr and underflowing pop in the same cycle → bit2 remains 1.
- Program test: ROM loads the input port, adds 1, writes output_port_1; feed 0xFE → output_port_1=0xFF at cpu_halt.
- With INPUT_PORT_SYNC_EN defined: hold ext_valid with 0xA5 → ext_ready high 3 cycles later, one push only; drop valid → ready low 3 cycles later; reset during ACK → ready=0, state IDLE.
